// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store pipeline stage: memOp codes, FSM states,
// bus field offsets and op decode helpers.
package lsu_pkg;

    localparam logic [3:0] OP_NONE = 4'h0;
    localparam logic [3:0] OP_LB   = 4'h1;
    localparam logic [3:0] OP_LH   = 4'h2;
    localparam logic [3:0] OP_LW   = 4'h3;
    localparam logic [3:0] OP_LBU  = 4'h4;
    localparam logic [3:0] OP_LHU  = 4'h5;
    localparam logic [3:0] OP_LWU  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_SB   = 4'h9;
    localparam logic [3:0] OP_SH   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_SD   = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // EXE->MEM bus: {regW, regAddr, aluRes, storeData, memOp[3:0]}
    function automatic int unsigned exe_sd_lsb();
        return 4;
    endfunction

    function automatic int unsigned exe_alu_lsb(input int unsigned dw);
        return dw + 4;
    endfunction

    function automatic int unsigned exe_ra_lsb(input int unsigned dw);
        return 2 * dw + 4;
    endfunction

    function automatic int unsigned exe_rw_bit(input int unsigned aw, input int unsigned dw);
        return 2 * dw + aw + 4;
    endfunction

    // MEM->WB bus: {misalign, regW, regAddr, regData}
    function automatic int unsigned wb_ra_lsb(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned wb_rw_bit(input int unsigned aw, input int unsigned dw);
        return dw + aw;
    endfunction

    function automatic int unsigned wb_mis_bit(input int unsigned aw, input int unsigned dw);
        return dw + aw + 1;
    endfunction

    // 64-bit-only codes and unused codes collapse to OP_NONE
    function automatic logic [3:0] op_legalize(input logic [3:0] op, input int unsigned dw);
        logic [3:0] res;
        res = OP_NONE;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: res = op;
            OP_LWU, OP_LD, OP_SD: res = (dw == 64) ? op : OP_NONE;
            default: res = OP_NONE;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] op_size_log2(input logic [3:0] op);
        logic [1:0] res;
        res = 2'd0;
        case (op)
            OP_LH, OP_LHU, OP_SH:  res = 2'd1;
            OP_LW, OP_LWU, OP_SW:  res = 2'd2;
            OP_LD, OP_SD:          res = 2'd3;
            default:               res = 2'd0;
        endcase
        return res;
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LD);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SD);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store data/strobe placement and load extraction with extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned NB         = DATA_WIDTH / 8,
    localparam int unsigned OB         = $clog2(NB)
) (
    input  logic [3:0]            i_op,
    input  logic [OB-1:0]         i_off,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] o_wdata_c,
    output logic [NB-1:0]         o_wstrb_c,
    output logic [DATA_WIDTH-1:0] o_ldata_c
);

    logic [DATA_WIDTH-1:0] w_sh;
    logic [NB-1:0]         w_mask;

    always_comb begin
        w_mask = '0;
        case (op_size_log2(i_op))
            2'd0:    w_mask = NB'(1);
            2'd1:    w_mask = NB'(3);
            2'd2:    w_mask = NB'(15);
            default: w_mask = NB'(255);
        endcase

        o_wdata_c = i_store_data << {i_off, 3'b000};
        o_wstrb_c = op_is_store(i_op) ? NB'(w_mask << i_off) : '0;

        // sized casts of signed slices sign-extend; of unsigned slices zero-extend
        w_sh = i_rdata >> {i_off, 3'b000};
        case (i_op)
            OP_LB:   o_ldata_c = DATA_WIDTH'($signed(w_sh[7:0]));
            OP_LH:   o_ldata_c = DATA_WIDTH'($signed(w_sh[15:0]));
            OP_LW:   o_ldata_c = DATA_WIDTH'($signed(w_sh[31:0]));
            OP_LBU:  o_ldata_c = DATA_WIDTH'(w_sh[7:0]);
            OP_LHU:  o_ldata_c = DATA_WIDTH'(w_sh[15:0]);
            OP_LWU:  o_ldata_c = DATA_WIDTH'(w_sh[31:0]);
            default: o_ldata_c = w_sh;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Memory stage between EXE and WB: one dmem transaction in flight, misalignment
// detection, and a registered write-back bus.
module lsu_stage
    import lsu_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 5,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned NB         = DATA_WIDTH / 8,
    localparam int unsigned OB         = $clog2(NB),
    localparam int unsigned EXE_W      = 2 * DATA_WIDTH + ADDR_WIDTH + 5,
    localparam int unsigned WB_W       = DATA_WIDTH + ADDR_WIDTH + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [EXE_W-1:0]      exe_to_mem_bus,
    input  logic                  exe_to_mem_valid,
    output logic                  mem_to_exe_ready,
    output logic [WB_W-1:0]       mem_to_wb_bus,
    output logic                  mem_to_wb_valid,
    input  logic                  wb_to_mem_ready,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_req_wen,
    output logic [DATA_WIDTH-1:0] dmem_req_addr,
    output logic [DATA_WIDTH-1:0] dmem_req_wdata,
    output logic [NB-1:0]         dmem_req_wstrb,
    input  logic                  dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] dmem_rsp_rdata
);

    localparam int unsigned SD_LSB  = exe_sd_lsb();
    localparam int unsigned ALU_LSB = exe_alu_lsb(DATA_WIDTH);
    localparam int unsigned RA_LSB  = exe_ra_lsb(DATA_WIDTH);
    localparam int unsigned RW_BIT  = exe_rw_bit(ADDR_WIDTH, DATA_WIDTH);

    lsu_state_e              r_state, w_state;
    logic [3:0]              r_op, w_op;
    logic [DATA_WIDTH-1:0]   r_alu, w_alu;
    logic [DATA_WIDTH-1:0]   r_sd, w_sd;
    logic                    r_regw, w_regw;
    logic [ADDR_WIDTH-1:0]   r_regaddr, w_regaddr;
    logic                    r_wb_mis, w_wb_mis;
    logic                    r_wb_regw, w_wb_regw;
    logic [ADDR_WIDTH-1:0]   r_wb_regaddr, w_wb_regaddr;
    logic [DATA_WIDTH-1:0]   r_wb_data, w_wb_data;

    logic [3:0]              w_in_op;
    logic [DATA_WIDTH-1:0]   w_in_alu;
    logic [DATA_WIDTH-1:0]   w_in_sd;
    logic [ADDR_WIDTH-1:0]   w_in_regaddr;
    logic                    w_in_regw;
    logic [3:0]              w_in_szmask;
    logic                    w_in_mem;
    logic                    w_in_mis;
    logic                    w_take;

    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [NB-1:0]           w_wstrb;
    logic [DATA_WIDTH-1:0]   w_ldata;

    assign w_in_op      = op_legalize(exe_to_mem_bus[3:0], DATA_WIDTH);
    assign w_in_sd      = exe_to_mem_bus[SD_LSB +: DATA_WIDTH];
    assign w_in_alu     = exe_to_mem_bus[ALU_LSB +: DATA_WIDTH];
    assign w_in_regaddr = exe_to_mem_bus[RA_LSB +: ADDR_WIDTH];
    assign w_in_regw    = exe_to_mem_bus[RW_BIT];
    assign w_in_szmask  = 4'((4'd1 << op_size_log2(w_in_op)) - 4'd1);
    assign w_in_mem     = op_is_load(w_in_op) | op_is_store(w_in_op);
    assign w_in_mis     = w_in_mem & (|(4'(w_in_alu[OB-1:0]) & w_in_szmask));

    // Alignment operates only on registered transaction state
    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .i_op         (r_op),
        .i_off        (r_alu[OB-1:0]),
        .i_store_data (r_sd),
        .i_rdata      (dmem_rsp_rdata),
        .o_wdata_c    (w_wdata),
        .o_wstrb_c    (w_wstrb),
        .o_ldata_c    (w_ldata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_NONE;
            r_alu        <= '0;
            r_sd         <= '0;
            r_regw       <= 1'b0;
            r_regaddr    <= '0;
            r_wb_mis     <= 1'b0;
            r_wb_regw    <= 1'b0;
            r_wb_regaddr <= '0;
            r_wb_data    <= '0;
        end else begin
            r_state      <= w_state;
            r_op         <= w_op;
            r_alu        <= w_alu;
            r_sd         <= w_sd;
            r_regw       <= w_regw;
            r_regaddr    <= w_regaddr;
            r_wb_mis     <= w_wb_mis;
            r_wb_regw    <= w_wb_regw;
            r_wb_regaddr <= w_wb_regaddr;
            r_wb_data    <= w_wb_data;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_op         = r_op;
        w_alu        = r_alu;
        w_sd         = r_sd;
        w_regw       = r_regw;
        w_regaddr    = r_regaddr;
        w_wb_mis     = r_wb_mis;
        w_wb_regw    = r_wb_regw;
        w_wb_regaddr = r_wb_regaddr;
        w_wb_data    = r_wb_data;
        w_take       = 1'b0;

        case (r_state)
            ST_IDLE: w_take = exe_to_mem_valid;
            ST_REQ: begin
                if (dmem_req_ready) w_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (dmem_rsp_valid) begin
                    w_state      = ST_DONE;
                    w_wb_mis     = 1'b0;
                    w_wb_regw    = op_is_store(r_op) ? 1'b0 : r_regw;
                    w_wb_regaddr = r_regaddr;
                    w_wb_data    = op_is_load(r_op) ? w_ldata : r_alu;
                end
            end
            ST_DONE: begin
                if (wb_to_mem_ready) begin
                    w_take  = exe_to_mem_valid;
                    w_state = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase

        // Bus acceptance is shared by IDLE and the pipelined DONE release
        if (w_take) begin
            w_op      = w_in_op;
            w_alu     = w_in_alu;
            w_sd      = w_in_sd;
            w_regw    = w_in_regw;
            w_regaddr = w_in_regaddr;
            if (w_in_mem && !w_in_mis) begin
                w_state = ST_REQ;
            end else begin
                w_state      = ST_DONE;
                w_wb_mis     = w_in_mis;
                w_wb_regw    = w_in_mis ? 1'b0 : w_in_regw;
                w_wb_regaddr = w_in_regaddr;
                w_wb_data    = w_in_alu;
            end
        end
    end

    assign mem_to_exe_ready = (r_state == ST_IDLE) | ((r_state == ST_DONE) & wb_to_mem_ready);
    assign mem_to_wb_valid  = (r_state == ST_DONE);
    assign mem_to_wb_bus    = {r_wb_mis, r_wb_regw, r_wb_regaddr, r_wb_data};
    assign dmem_req_valid   = (r_state == ST_REQ);
    assign dmem_req_wen     = op_is_store(r_op);
    assign dmem_req_addr    = {r_alu[DATA_WIDTH-1:OB], {OB{1'b0}}};
    assign dmem_req_wdata   = w_wdata;
    assign dmem_req_wstrb   = w_wstrb;

endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage: 32- and 64-bit instances driven from shared stimulus and
// checked against a byte-level reference model.
module tb_lsu_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel64;
    logic        f_regw;
    logic [4:0]  f_regaddr;
    logic [63:0] f_alu, f_sd;
    logic [3:0]  f_op;
    logic        exe_valid, wb_ready, req_ready, rsp_valid;
    logic [63:0] rdata;

    logic [73:0]  bus32;
    logic [137:0] bus64;
    assign bus32 = {f_regw, f_regaddr, f_alu[31:0], f_sd[31:0], f_op};
    assign bus64 = {f_regw, f_regaddr, f_alu, f_sd, f_op};

    logic        rdy32, wbv32, rqv32, wen32;
    logic [38:0] wb32;
    logic [31:0] addr32, wd32;
    logic [3:0]  ws32;
    logic        rdy64, wbv64, rqv64, wen64;
    logic [70:0] wb64;
    logic [63:0] addr64, wd64;
    logic [7:0]  ws64;

    lsu_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .exe_to_mem_bus(bus32), .exe_to_mem_valid(exe_valid & ~sel64), .mem_to_exe_ready(rdy32),
        .mem_to_wb_bus(wb32), .mem_to_wb_valid(wbv32), .wb_to_mem_ready(wb_ready),
        .dmem_req_valid(rqv32), .dmem_req_ready(req_ready), .dmem_req_wen(wen32),
        .dmem_req_addr(addr32), .dmem_req_wdata(wd32), .dmem_req_wstrb(ws32),
        .dmem_rsp_valid(rsp_valid), .dmem_rsp_rdata(rdata[31:0])
    );

    lsu_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) u_dut64 (
        .clk(clk), .rst(rst),
        .exe_to_mem_bus(bus64), .exe_to_mem_valid(exe_valid & sel64), .mem_to_exe_ready(rdy64),
        .mem_to_wb_bus(wb64), .mem_to_wb_valid(wbv64), .wb_to_mem_ready(wb_ready),
        .dmem_req_valid(rqv64), .dmem_req_ready(req_ready), .dmem_req_wen(wen64),
        .dmem_req_addr(addr64), .dmem_req_wdata(wd64), .dmem_req_wstrb(ws64),
        .dmem_rsp_valid(rsp_valid), .dmem_rsp_rdata(rdata)
    );

    // View of whichever instance is currently selected
    logic        o_rdy, o_wbv, o_rqv, o_wen, o_regw, o_mis;
    logic [4:0]  o_regaddr;
    logic [63:0] o_addr, o_wdata, o_regdata;
    logic [7:0]  o_wstrb;
    always_comb begin
        o_rdy     = sel64 ? rdy64 : rdy32;
        o_wbv     = sel64 ? wbv64 : wbv32;
        o_rqv     = sel64 ? rqv64 : rqv32;
        o_wen     = sel64 ? wen64 : wen32;
        o_addr    = sel64 ? addr64 : {32'b0, addr32};
        o_wdata   = sel64 ? wd64 : {32'b0, wd32};
        o_wstrb   = sel64 ? ws64 : {4'b0, ws32};
        o_regdata = sel64 ? wb64[63:0] : {32'b0, wb32[31:0]};
        o_regaddr = sel64 ? wb64[68:64] : wb32[36:32];
        o_regw    = sel64 ? wb64[69] : wb32[37];
        o_mis     = sel64 ? wb64[70] : wb32[38];
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          mem;
        bit          misal;
        bit          wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        bit          regw;
        logic [63:0] data;
    } exp_t;

    // Reference: decode op to (kind, size, signedness), then byte arithmetic
    function automatic exp_t model(input bit w64, input logic [3:0] op, input logic [63:0] alu_i,
                                   input logic [63:0] sd_i, input logic [63:0] rd_i, input bit regw);
        exp_t e;
        int nb, size, off;
        bit ld, st, sgn;
        logic [63:0] dm, alu, sd, rd, sh, m, v;
        nb = w64 ? 8 : 4;
        dm = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        alu = alu_i & dm; sd = sd_i & dm; rd = rd_i & dm;
        ld = 0; st = 0; sgn = 0; size = 1;
        case (op)
            4'h1: begin ld = 1; size = 1; sgn = 1; end
            4'h2: begin ld = 1; size = 2; sgn = 1; end
            4'h3: begin ld = 1; size = 4; sgn = 1; end
            4'h4: begin ld = 1; size = 1; end
            4'h5: begin ld = 1; size = 2; end
            4'h6: if (w64) begin ld = 1; size = 4; end
            4'h7: if (w64) begin ld = 1; size = 8; sgn = 1; end
            4'h9: begin st = 1; size = 1; end
            4'hA: begin st = 1; size = 2; end
            4'hB: begin st = 1; size = 4; end
            4'hC: if (w64) begin st = 1; size = 8; end
            default: ;
        endcase
        off = int'(alu[2:0]) % nb;
        e = '{default: 0};
        e.regw = regw;
        e.data = alu;
        if (ld || st) begin
            if (off % size != 0) begin
                e.misal = 1;
                e.regw  = 0;
            end else begin
                e.mem  = 1;
                e.wen  = st;
                e.addr = alu - 64'(off);
                if (st) begin
                    e.wdata = (sd << (8 * off)) & dm;
                    e.wstrb = 8'(((1 << size) - 1) << off);
                    e.regw  = 0;
                end else begin
                    sh = rd >> (8 * off);
                    if (size == 8) v = sh;
                    else begin
                        m = (64'd1 << (8 * size)) - 64'd1;
                        v = sh & m;
                        if (sgn && v[8 * size - 1]) v = v | ~m;
                    end
                    e.data = v & dm;
                end
            end
        end
        return e;
    endfunction

    task automatic drive_bus(input bit w64, input logic [3:0] op, input logic [63:0] alu,
                             input logic [63:0] sd, input bit regw, input logic [4:0] ra);
        sel64 = w64; f_op = op; f_alu = alu; f_sd = sd; f_regw = regw; f_regaddr = ra;
    endtask

    // Present a bus from IDLE; returns at the negedge of the first cycle after acceptance
    task automatic accept_txn(input bit w64, input logic [3:0] op, input logic [63:0] alu,
                              input logic [63:0] sd, input bit regw, input logic [4:0] ra);
        @(negedge clk);
        drive_bus(w64, op, alu, sd, regw, ra);
        exe_valid = 1'b1;
        #1;
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b want 1", o_rdy); end
        @(posedge clk);
        @(negedge clk);
        exe_valid = 1'b0;
    endtask

    // Walk REQ/WAIT (if any) into DONE; returns at a DONE negedge with wb_ready low
    task automatic finish_txn(input exp_t e, input logic [4:0] ra, input logic [63:0] rd,
                              input int req_stall, input int rsp_delay, input int wb_stall, input string tag);
        if (e.mem) begin
            for (int k = 0; k <= req_stall; k++) begin
                checks++; if (o_rqv !== 1'b1) begin errors++; $display("FAIL %s req_valid: got %b want 1", tag, o_rqv); end
                checks++; if (o_wen !== e.wen) begin errors++; $display("FAIL %s req_wen: got %b want %b", tag, o_wen, e.wen); end
                checks++; if (o_addr !== e.addr) begin errors++; $display("FAIL %s req_addr: got %h want %h", tag, o_addr, e.addr); end
                checks++; if (o_wstrb !== e.wstrb) begin errors++; $display("FAIL %s req_wstrb: got %h want %h", tag, o_wstrb, e.wstrb); end
                if (e.wen) begin
                    checks++; if (o_wdata !== e.wdata) begin errors++; $display("FAIL %s req_wdata: got %h want %h", tag, o_wdata, e.wdata); end
                end
                checks++; if (o_wbv !== 1'b0) begin errors++; $display("FAIL %s early_wb_valid(req): got %b want 0", tag, o_wbv); end
                if (k == req_stall) req_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                req_ready = 1'b0;
            end
            for (int k = 0; k <= rsp_delay; k++) begin
                checks++; if (o_rqv !== 1'b0) begin errors++; $display("FAIL %s req_valid_wait: got %b want 0", tag, o_rqv); end
                checks++; if (o_wbv !== 1'b0) begin errors++; $display("FAIL %s early_wb_valid(wait): got %b want 0", tag, o_wbv); end
                if (k == rsp_delay) begin rsp_valid = 1'b1; rdata = rd; end
                @(posedge clk);
                @(negedge clk);
                rsp_valid = 1'b0;
                rdata = {$urandom, $urandom};
            end
        end
        for (int k = 0; k <= wb_stall; k++) begin
            checks++; if (o_wbv !== 1'b1) begin errors++; $display("FAIL %s wb_valid: got %b want 1", tag, o_wbv); end
            checks++; if (o_rqv !== 1'b0) begin errors++; $display("FAIL %s req_valid_done: got %b want 0", tag, o_rqv); end
            checks++; if (o_mis !== e.misal) begin errors++; $display("FAIL %s misalign: got %b want %b", tag, o_mis, e.misal); end
            checks++; if (o_regw !== e.regw) begin errors++; $display("FAIL %s regW: got %b want %b", tag, o_regw, e.regw); end
            checks++; if (o_regaddr !== ra) begin errors++; $display("FAIL %s regAddr: got %h want %h", tag, o_regaddr, ra); end
            checks++; if (o_regdata !== e.data) begin errors++; $display("FAIL %s regData: got %h want %h", tag, o_regdata, e.data); end
            checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL %s exe_ready_done_stall: got %b want 0", tag, o_rdy); end
            if (k < wb_stall) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic release_idle(input string tag);
        wb_ready = 1'b1;
        #1;
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL %s exe_ready_release: got %b want 1", tag, o_rdy); end
        @(posedge clk);
        @(negedge clk);
        wb_ready = 1'b0;
        checks++; if (o_wbv !== 1'b0) begin errors++; $display("FAIL %s wb_valid_idle: got %b want 0", tag, o_wbv); end
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL %s exe_ready_idle: got %b want 1", tag, o_rdy); end
    endtask

    task automatic run_txn(input bit w64, input logic [3:0] op, input logic [63:0] alu, input logic [63:0] sd,
                           input bit regw, input logic [4:0] ra, input logic [63:0] rd,
                           input int rs, input int rd_dly, input int ws, input string tag);
        exp_t e;
        e = model(w64, op, alu, sd, rd, regw);
        accept_txn(w64, op, alu, sd, regw, ra);
        finish_txn(e, ra, rd, rs, rd_dly, ws, tag);
        release_idle(tag);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sel64 = w[0];
            #1;
            checks++; if (o_wbv !== 1'b0) begin errors++; $display("FAIL reset wb_valid w64=%0d: got %b want 0", w, o_wbv); end
            checks++; if (o_rqv !== 1'b0) begin errors++; $display("FAIL reset req_valid w64=%0d: got %b want 0", w, o_rqv); end
            checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL reset exe_ready w64=%0d: got %b want 1", w, o_rdy); end
            checks++; if ({o_mis, o_regw, o_regaddr, o_regdata} !== 71'd0) begin errors++; $display("FAIL reset wb_bus w64=%0d: got %h want 0", w, {o_mis, o_regw, o_regaddr, o_regdata}); end
            checks++; if (o_wstrb !== 8'd0) begin errors++; $display("FAIL reset wstrb w64=%0d: got %h want 0", w, o_wstrb); end
        end
        rst = 1'b1;
    endtask

    task automatic test_directed32();
        run_txn(0, 4'h0, 64'h1234, 64'h5555, 1, 5'd5, 64'h0, 0, 0, 0, "op0");
        run_txn(0, 4'h9, 64'h1003, 64'hAB, 1, 5'd3, 64'h0, 0, 0, 0, "sb");
        run_txn(0, 4'h2, 64'h2002, 64'h0, 1, 5'd7, 64'h80017FFF, 0, 0, 0, "lh");
        run_txn(0, 4'h5, 64'h2002, 64'h0, 1, 5'd8, 64'h80017FFF, 0, 1, 0, "lhu");
        run_txn(0, 4'h1, 64'h2001, 64'h0, 1, 5'd9, 64'h80017FFF, 0, 0, 0, "lb");
        run_txn(0, 4'h3, 64'h2001, 64'h0, 1, 5'd10, 64'h0, 0, 0, 0, "lw_misalign");
        run_txn(0, 4'h7, 64'h3000, 64'h0, 1, 5'd11, 64'hFFFF, 0, 0, 0, "ld_on_32");
    endtask

    task automatic test_backpressure();
        exp_t e1, e2;
        run_txn(0, 4'hB, 64'h4008, 64'hDEADBEEF, 1, 5'd12, 64'h0, 3, 0, 0, "req_stall");
        e1 = model(0, 4'h0, 64'h77, 64'h0, 64'h0, 1);
        accept_txn(0, 4'h0, 64'h77, 64'h0, 1, 5'd13);
        finish_txn(e1, 5'd13, 64'h0, 0, 0, 2, "wb_stall");
        e2 = model(0, 4'h3, 64'h5004, 64'h0, 64'hCAFEF00D, 1);
        drive_bus(0, 4'h3, 64'h5004, 64'h0, 1, 5'd14);
        exe_valid = 1'b1;
        wb_ready  = 1'b1;
        #1;
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL pipelined_ready: got %b want 1", o_rdy); end
        @(posedge clk);
        @(negedge clk);
        exe_valid = 1'b0;
        wb_ready  = 1'b0;
        finish_txn(e2, 5'd14, 64'hCAFEF00D, 0, 0, 0, "pipelined_lw");
        release_idle("pipelined_lw");
    endtask

    task automatic test_back_to_back();
        localparam int N = 8;
        exp_t e[N];
        logic [3:0]  op[N];
        logic [63:0] alu[N];
        logic [4:0]  ra[N];
        bit          rw[N];
        for (int i = 0; i < N; i++) begin
            op[i]  = ($urandom_range(0, 3) == 0) ? 4'h3 : 4'h0;
            alu[i] = {32'h0, $urandom};
            if (op[i] == 4'h3) alu[i][1:0] = 2'(($urandom_range(1, 3)));
            ra[i]  = 5'($urandom);
            rw[i]  = 1'($urandom);
            e[i]   = model(0, op[i], alu[i], 64'h0, 64'h0, rw[i]);
        end
        @(negedge clk);
        wb_ready = 1'b1;
        drive_bus(0, op[0], alu[0], 64'h0, rw[0], ra[0]);
        exe_valid = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= N; i++) begin
            @(negedge clk);
            checks++; if (o_wbv !== 1'b1) begin errors++; $display("FAIL b2b[%0d] wb_valid: got %b want 1", i - 1, o_wbv); end
            checks++; if ({o_mis, o_regw, o_regaddr, o_regdata} !== {e[i-1].misal, e[i-1].regw, ra[i-1], e[i-1].data}) begin
                errors++; $display("FAIL b2b[%0d] wb_bus: got %h want %h", i - 1, {o_mis, o_regw, o_regaddr, o_regdata},
                                   {e[i-1].misal, e[i-1].regw, ra[i-1], e[i-1].data});
            end
            if (i < N) drive_bus(0, op[i], alu[i], 64'h0, rw[i], ra[i]);
            else exe_valid = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        wb_ready = 1'b0;
        checks++; if (o_wbv !== 1'b0) begin errors++; $display("FAIL b2b end wb_valid: got %b want 0", o_wbv); end
    endtask

    task automatic test_w64();
        run_txn(1, 4'h6, 64'h0000_1000_0000_0104, 64'h0, 1, 5'd20, 64'h80000000_12345678, 0, 0, 0, "lwu64");
        run_txn(1, 4'hC, 64'h0000_0000_0000_2008, 64'h0123_4567_89AB_CDEF, 1, 5'd21, 64'h0, 1, 0, 0, "sd64");
        run_txn(1, 4'h7, 64'h0000_0000_0000_3000, 64'h0, 1, 5'd22, 64'h8000_0000_0000_0001, 0, 0, 1, "ld64");
        // reset while waiting for the response; the late response must be ignored
        accept_txn(1, 4'h7, 64'h6000, 64'h0, 1, 5'd23);
        req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rsp_valid = 1'b1;
        rdata = 64'h1111_2222_3333_4444;
        @(posedge clk);
        @(negedge clk);
        rsp_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_wbv !== 1'b0) begin errors++; $display("FAIL rst_wait wb_valid[%0d]: got %b want 0", k, o_wbv); end
            checks++; if (o_rqv !== 1'b0) begin errors++; $display("FAIL rst_wait req_valid[%0d]: got %b want 0", k, o_rqv); end
            checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL rst_wait exe_ready[%0d]: got %b want 1", k, o_rdy); end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 150; t++) begin
            run_txn(1'($urandom), 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
                    1'($urandom), 5'($urandom), {$urandom, $urandom},
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), "rand");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; sel64 = 1'b0; exe_valid = 1'b0; wb_ready = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rdata = '0;
        drive_bus(0, 4'h0, 64'h0, 64'h0, 0, 5'd0);
        test_reset();
        test_directed32();
        test_backpressure();
        test_back_to_back();
        test_w64();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
